alu_block: RTL and testbench

Registered WIDTH-bit ALU built from a ripple chain of 1-bit slices, supporting AND, OR, ADD and SUB selected by a 2-bit control code. It is the arithmetic/logic stage of the datapath: operands, carry-in and control are sampled every clock, and result and carry-out are presented one cycle later. At WIDTH=1 it is the single-bit ALU cell used when composing wider ALUs externally.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_bit_slice.sv | 44 ++++
 rtl/alu_block.sv | 88 ++++++++
 tb/tb_alu_block.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath stage: the 2-bit operation code
// type, its named encodings, and a helper that tells arithmetic codes apart
// from bitwise ones.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 2'b00;
    localparam alu_op_t ALU_OR  = 2'b01;
    localparam alu_op_t ALU_ADD = 2'b10;
    localparam alu_op_t ALU_SUB = 2'b11;

    // ADD and SUB share the MSB of the code; AND/OR never touch the carry chain.
    function automatic logic is_arith(input alu_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice
// Combinational 1-bit ALU cell. Chained through cin/cout to build wider ALUs.
//
// Ports:
//   a, b  operand bits
//   cin   carry from the next-lower slice (or the block carry-in)
//   op    operation code (alu_pkg::alu_op_t)
//   res   result bit
//   cout  carry to the next-higher slice; forced to 0 for AND/OR so that the
//         block carry-out is 0 for logic operations
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_t op,
    output logic    res,
    output logic    cout
);

    logic b_eff;
    logic sum;
    logic carry;

    // SUB is in1 + ~in2 + carryin, so the B operand is inverted here.
    assign b_eff = (op == ALU_SUB) ? ~b : b;
    assign sum   = a ^ b_eff ^ cin;
    assign carry = (a & b_eff) | (cin & (a ^ b_eff));

    always_comb begin
        res  = 1'b0;
        cout = 1'b0;
        case (op)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: begin
                res  = sum;
                cout = carry;
            end
        endcase
    end

endmodule

// File: rtl/alu_block.sv
// alu_block
// Registered WIDTH-bit ALU (AND / OR / ADD / SUB) built from a ripple chain
// of alu_bit_slice cells. Inputs are sampled every rising clk edge and the
// result appears one cycle later; there is no handshake.
//
// Optional feature macro: ALU_BLOCK_FLAGS_EN
//   When defined, the zero and overflow flag ports and registers exist.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset, clears all outputs
//   in1, in2  WIDTH-bit operands
//   carryin   carry into slice 0 (used by ADD/SUB only)
//   control   operation select (see alu_pkg)
//   result    registered WIDTH-bit result
//   carryout  registered carry out of the MSB slice
//   zero      registered result==0 flag          (ALU_BLOCK_FLAGS_EN only)
//   overflow  registered signed overflow flag    (ALU_BLOCK_FLAGS_EN only)
module alu_block
    import alu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carryin,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] result,
`ifdef ALU_BLOCK_FLAGS_EN
    output logic             carryout,
    output logic             zero,
    output logic             overflow
`else
    output logic             carryout
`endif
);

    alu_op_t          op;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] result_next;

    assign op       = alu_op_t'(control);
    assign carry[0] = carryin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (carry[i]),
            .op   (op),
            .res  (result_next[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            carryout <= 1'b0;
        end else begin
            result   <= result_next;
            carryout <= carry[WIDTH];
        end
    end

`ifdef ALU_BLOCK_FLAGS_EN
    logic zero_next;
    logic overflow_next;

    assign zero_next = ~|result_next;
    // Signed overflow: carry into the MSB differs from carry out of it.
    // Slice 0 sees carryin even for logic ops, so gate by operation class.
    assign overflow_next = is_arith(op) & (carry[WIDTH] ^ carry[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            zero     <= zero_next;
            overflow <= overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_block.sv
// tb_alu_block
// Drives a WIDTH=8 and a WIDTH=1 alu_block from the same operand bus (the
// 1-bit instance sees bit 0). Expected responses are queued when stimulus is
// applied and popped by an independent monitor once the capturing edge has
// passed.
module tb_alu_block;
    import alu_pkg::*;

    typedef struct {
        int unsigned tag;
        logic [7:0]  res;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       carryin;
    logic [1:0] control;

    logic [7:0] result8;
    logic       carryout8;
    logic [0:0] result1;
    logic       carryout1;
`ifdef ALU_BLOCK_FLAGS_EN
    logic       zero8, overflow8, zero1, overflow1;
`endif

    int unsigned cyc;
    int          n_checks;
    int          n_fails;
    exp_t        q8[$];
    exp_t        q1[$];

    alu_block #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .carryin  (carryin),
        .control  (control),
        .result   (result8),
`ifdef ALU_BLOCK_FLAGS_EN
        .carryout (carryout8),
        .zero     (zero8),
        .overflow (overflow8)
`else
        .carryout (carryout8)
`endif
    );

    alu_block #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1[0:0]),
        .in2      (in2[0:0]),
        .carryin  (carryin),
        .control  (control),
        .result   (result1),
`ifdef ALU_BLOCK_FLAGS_EN
        .carryout (carryout1),
        .zero     (zero1),
        .overflow (overflow1)
`else
        .carryout (carryout1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on a w-bit unsigned operand pair.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic [1:0] op);
        exp_t        e;
        longint      mask, aa, bb, full, r, msb;
        mask  = (64'sd1 <<< w) - 1;
        aa    = longint'(a) & mask;
        bb    = longint'(b) & mask;
        msb   = 64'sd1 <<< (w - 1);
        e.tag = cyc;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (op)
            ALU_AND: r = aa & bb;
            ALU_OR:  r = aa | bb;
            default: begin
                if (op == ALU_SUB) bb = (~bb) & mask;
                full   = aa + bb + longint'(cin);
                r      = full & mask;
                e.cout = ((full >>> w) & 1) != 0;
                // Signed overflow: same-signed operands give a differently signed sum.
                e.ovf  = (((aa & msb) != 0) == ((bb & msb) != 0)) &&
                         (((r & msb) != 0) != ((aa & msb) != 0));
            end
        endcase
        e.res  = r[7:0];
        e.zero = (r == 0);
        return e;
    endfunction

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [1:0] op);
        in1     = a;
        in2     = b;
        carryin = cin;
        control = op;
        q8.push_back(model(8, a, b, cin, op));
        q1.push_back(model(1, a, b, cin, op));
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [1:0] op);
        @(posedge clk);
        #1;
        apply(a, b, cin, op);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q8.size() != 0 || q1.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d/%0d responses never appeared", q8.size(), q1.size());
            q8.delete();
            q1.delete();
        end
    endtask

    // Monitor: compares once the edge that captured the queued inputs has passed.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && q8.size() != 0 && q8[0].tag < cyc) begin
            e = q8.pop_front();
            check("w8_result", {8'h0, result8}, {8'h0, e.res});
            check("w8_carryout", {15'h0, carryout8}, {15'h0, e.cout});
`ifdef ALU_BLOCK_FLAGS_EN
            check("w8_zero", {15'h0, zero8}, {15'h0, e.zero});
            check("w8_overflow", {15'h0, overflow8}, {15'h0, e.ovf});
`endif
        end
        if (!rst && q1.size() != 0 && q1[0].tag < cyc) begin
            e = q1.pop_front();
            check("w1_result", {15'h0, result1}, {15'h0, e.res[0]});
            check("w1_carryout", {15'h0, carryout1}, {15'h0, e.cout});
`ifdef ALU_BLOCK_FLAGS_EN
            check("w1_zero", {15'h0, zero1}, {15'h0, e.zero});
            check("w1_overflow", {15'h0, overflow1}, {15'h0, e.ovf});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        in1      = 8'h00;
        in2      = 8'h00;
        carryin  = 1'b0;
        control  = ALU_AND;
        #1;
        check("reset_result8", {8'h0, result8}, 16'h0);
        check("reset_carryout8", {15'h0, carryout8}, 16'h0);
        check("reset_result1", {15'h0, result1}, 16'h0);
        check("reset_carryout1", {15'h0, carryout1}, 16'h0);
`ifdef ALU_BLOCK_FLAGS_EN
        check("reset_zero8", {15'h0, zero8}, 16'h0);
        check("reset_overflow8", {15'h0, overflow8}, 16'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, issued back to back.
        step(8'h01, 8'h00, 1'b0, ALU_AND);
        step(8'h01, 8'h00, 1'b0, ALU_ADD);
        step(8'h01, 8'h00, 1'b0, ALU_SUB);
        step(8'h01, 8'h01, 1'b1, ALU_ADD);
        step(8'h01, 8'h01, 1'b1, ALU_OR);
        step(8'h05, 8'h07, 1'b1, ALU_SUB);
        step(8'h7F, 8'h01, 1'b0, ALU_ADD);
        step(8'hC3, 8'h5A, 1'b0, ALU_AND);
        step(8'hFF, 8'h01, 1'b0, ALU_ADD);
        step(8'h80, 8'h01, 1'b1, ALU_SUB);
        step(8'h00, 8'h00, 1'b1, ALU_OR);
        drain(10);

        // Asynchronous reset between edges after an ADD producing 8'hFF.
        step(8'hF0, 8'h0E, 1'b1, ALU_ADD);
        drain(10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result8", {8'h0, result8}, 16'h0);
        check("async_rst_carryout8", {15'h0, carryout8}, 16'h0);
        check("async_rst_result1", {15'h0, result1}, 16'h0);
`ifdef ALU_BLOCK_FLAGS_EN
        check("async_rst_zero8", {15'h0, zero8}, 16'h0);
        check("async_rst_overflow8", {15'h0, overflow8}, 16'h0);
`endif
        #1;
        rst = 1'b0;
        apply(8'h12, 8'h35, 1'b0, ALU_ADD);
        drain(10);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
        end
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
